// File: rtl/apb_uart_pkg.sv
// Shared constants, command record and FSM state encoding for the APB command UART packer.
// Define PACKER_CHECKSUM_EN to append an XOR checksum byte to every frame.
package apb_uart_pkg;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;
    localparam logic [1:0] SEL_S1     = 2'b01;
    localparam logic [1:0] SEL_S2     = 2'b10;

`ifdef PACKER_CHECKSUM_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [1:0]  sel;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Bytes 0..8 of a frame; any other index (including the checksum slot) reads as zero.
    function automatic logic [7:0] frame_byte(input cmd_t c, input logic [3:0] idx);
        case (idx)
            4'd0:    frame_byte = {HDR_NIBBLE, 1'b0, c.write, c.sel};
            4'd1:    frame_byte = c.addr[31:24];
            4'd2:    frame_byte = c.addr[23:16];
            4'd3:    frame_byte = c.addr[15:8];
            4'd4:    frame_byte = c.addr[7:0];
            4'd5:    frame_byte = c.wdata[31:24];
            4'd6:    frame_byte = c.wdata[23:16];
            4'd7:    frame_byte = c.wdata[15:8];
            4'd8:    frame_byte = c.wdata[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit.
// A new byte may be loaded in the same cycle the current stop bit ends, giving gap-free streams.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx_out,
    output logic       byte_done
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active_q;
    logic [CW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;
    logic          tx_q;
    logic          bit_end;
    logic          load;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign byte_done = active_q && bit_end && (bit_q == 4'd9);
    assign load      = start && (!active_q || byte_done);
    assign tx_out    = tx_q;

    // bit_q counts 0 = start bit, 1..8 = data bits, 9 = stop bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else if (load) begin
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= {1'b1, din};
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (bit_end) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_q <= baud_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/apb_cmd_uart_packer.sv
// Accepts one APB command over valid/ready and sends it as a gap-free UART 8N1 byte frame.
// Define PACKER_CHECKSUM_EN to append a 10th byte holding the XOR of bytes 0..8.
module apb_cmd_uart_packer
    import apb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_sel,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_e     state_q;
    cmd_t       cmd_q;
    logic [3:0] idx_q;
    logic       cmd_ready_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic       accept;
    logic       sel_legal;
    logic       last_byte;
    logic       ser_start;
    logic       byte_done;
    logic [3:0] din_idx;
    logic [7:0] ser_din;

    assign accept    = cmd_valid && cmd_ready_q;
    assign sel_legal = (cmd_sel == SEL_S1) || (cmd_sel == SEL_S2);
    assign last_byte = (idx_q == LAST_IDX);

    // NOTE: the reload between bytes must land on the very edge the stop bit ends, so the
    // serialiser start is decoded combinationally; in LOAD after a reload it is ignored
    // because the serialiser is already busy.
    assign ser_start = (state_q == S_LOAD) || ((state_q == S_SEND) && byte_done && !last_byte);
    assign din_idx   = (state_q == S_SEND) ? idx_q + 4'd1 : idx_q;

`ifdef PACKER_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = 8'h00;
        for (int i = 0; i < 9; i++) begin
            checksum = checksum ^ frame_byte(cmd_q, 4'(i));
        end
    end

    always_comb begin
        ser_din = frame_byte(cmd_q, din_idx);
        if (din_idx == LAST_IDX) begin
            ser_din = checksum;
        end
    end
`else
    always_comb begin
        ser_din = frame_byte(cmd_q, din_idx);
    end
`endif

    // NOTE: the command register is pure datapath, only read while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q.sel   <= cmd_sel;
            cmd_q.write <= cmd_write;
            cmd_q.addr  <= cmd_addr;
            cmd_q.wdata <= cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        if (sel_legal) begin
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            idx_q       <= 4'd0;
                            state_q     <= S_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (byte_done) begin
                        if (last_byte) begin
                            idx_q   <= 4'd0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (ser_start),
        .din       (ser_din),
        .tx_out    (tx_out),
        .byte_done (byte_done)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_apb_cmd_uart_packer.sv
// Directed bench for apb_cmd_uart_packer at CLKS_PER_BIT = 4, decoding the serial line.
// Build with PACKER_CHECKSUM_EN defined to exercise the checksum frame variant.
module tb_apb_cmd_uart_packer;

    localparam int CPB = 4;
`ifdef PACKER_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int DONE_LAT = 2 + 10 * CPB * NB;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_sel   = 2'b00;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        cmd_ready;
    logic        tx_out;
    logic        busy;
    logic        done;
    logic        err;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          acc_cyc      = 0;
    int          start_cyc    = 0;
    bit          rx_ok;
    logic [7:0]  rx_bytes [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_cmd_uart_packer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .tx_out    (tx_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic logic [7:0] exp_byte(input logic [1:0] s, input logic w,
                                            input logic [31:0] a, input logic [31:0] d,
                                            input int idx);
        logic [7:0] b [9];
        logic [7:0] cs;
        b[0] = {4'hA, 1'b0, w, s};
        b[1] = a[31:24]; b[2] = a[23:16]; b[3] = a[15:8]; b[4] = a[7:0];
        b[5] = d[31:24]; b[6] = d[23:16]; b[7] = d[15:8]; b[8] = d[7:0];
        if (idx < 9) return b[idx];
        cs = 8'h00;
        for (int i = 0; i < 9; i++) cs = cs ^ b[i];
        return cs;
    endfunction

    // Presents a command at a falling edge, waits for acceptance, returns one cycle after it.
    task automatic issue(input logic [1:0] s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        int n;
        @(negedge clk);
        cmd_sel = s; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_wait: cmd_ready=%b, required 1", cmd_ready);
        end
        acc_cyc = cyc;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // UART receiver: samples each bit near its centre; returns at the last stop-bit sample.
    task automatic rx_frame(input int nb);
        int n;
        rx_ok     = 1'b1;
        start_cyc = -1;
        for (int b = 0; b < 10; b++) rx_bytes[b] = 8'hxx;
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (tx_out !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (tx_out !== 1'b0) begin
                rx_ok = 1'b0;
                break;
            end
            if (b == 0) start_cyc = cyc;
            repeat (2) @(negedge clk);
            if (tx_out !== 1'b0) rx_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx_bytes[b][i] = tx_out;
            end
            repeat (CPB) @(negedge clk);
            if (tx_out !== 1'b1) rx_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_out, cmd_ready, busy, done, err} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_values: {tx,ready,busy,done,err}=%b, required 10000",
                     {tx_out, cmd_ready, busy, done, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_write_s1();
        logic [31:0] a = 32'h0000_0010;
        logic [31:0] d = 32'hDEAD_BEEF;
        issue(2'b01, 1'b1, a, d, 1'b0);
        tests_run++;
        if ({busy, tx_out, cmd_ready} !== 3'b110) begin
            tests_failed++;
            $display("FAIL wr_load_cycle: {busy,tx,ready}=%b, required 110", {busy, tx_out, cmd_ready});
        end
        rx_frame(NB);
        tests_run++;
        if (!rx_ok) begin
            tests_failed++;
            $display("FAIL wr_framing: start/stop bits wrong or line stalled");
        end
        tests_run++;
        if (start_cyc !== acc_cyc + 2) begin
            tests_failed++;
            $display("FAIL wr_start_latency: %0d cycles, required 2", start_cyc - acc_cyc);
        end
        for (int b = 0; b < NB; b++) begin
            tests_run++;
            if (rx_bytes[b] !== exp_byte(2'b01, 1'b1, a, d, b)) begin
                tests_failed++;
                $display("FAIL wr_byte%0d: got %h, required %h", b, rx_bytes[b],
                         exp_byte(2'b01, 1'b1, a, d, b));
            end
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_done_early: done=%b one cycle before expected, required 0", done);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || cyc - acc_cyc != DONE_LAT) begin
            tests_failed++;
            $display("FAIL wr_done_latency: done=%b at %0d cycles, required 1 at %0d",
                     done, cyc - acc_cyc, DONE_LAT);
        end
        @(negedge clk);
        tests_run++;
        if ({done, cmd_ready, busy} !== 3'b010) begin
            tests_failed++;
            $display("FAIL wr_after_done: {done,ready,busy}=%b, required 010", {done, cmd_ready, busy});
        end
    endtask

    task automatic test_read_s2();
        logic [31:0] a = 32'h1234_5678;
        logic [31:0] d = 32'h0000_0000;
        issue(2'b10, 1'b0, a, d, 1'b0);
        rx_frame(NB);
        tests_run++;
        if (!rx_ok || start_cyc !== acc_cyc + 2) begin
            tests_failed++;
            $display("FAIL rd_framing: ok=%0d start=%0d cycles, required ok=1 start=2",
                     rx_ok, start_cyc - acc_cyc);
        end
        for (int b = 0; b < NB; b++) begin
            tests_run++;
            if (rx_bytes[b] !== exp_byte(2'b10, 1'b0, a, d, b)) begin
                tests_failed++;
                $display("FAIL rd_byte%0d: got %h, required %h", b, rx_bytes[b],
                         exp_byte(2'b10, 1'b0, a, d, b));
            end
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_done: done=%b at %0d cycles, required 1", done, cyc - acc_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_illegal_sel();
        logic [1:0] bad [2];
        int err_n, tx_low, ready_low;
        bad[0] = 2'b11;
        bad[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            issue(bad[k], 1'b1, 32'hFFFF_0000, 32'h1111_2222, 1'b0);
            tests_run++;
            if ({err, cmd_ready, busy} !== 3'b110) begin
                tests_failed++;
                $display("FAIL ill_err_pulse sel=%b: {err,ready,busy}=%b, required 110",
                         bad[k], {err, cmd_ready, busy});
            end
            err_n = 0; tx_low = 0; ready_low = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (err === 1'b1) err_n++;
                if (tx_out !== 1'b1) tx_low++;
                if (cmd_ready !== 1'b1) ready_low++;
            end
            tests_run++;
            if (err_n != 0 || tx_low != 0 || ready_low != 0) begin
                tests_failed++;
                $display("FAIL ill_quiet sel=%b: extra err=%0d tx low=%0d ready low=%0d, required 0/0/0",
                         bad[k], err_n, tx_low, ready_low);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1 = 32'hCAFE_0004;
        logic [31:0] d1 = 32'h8001_7E3C;
        logic [31:0] a2 = 32'hAAAA_5555;
        logic [31:0] d2 = 32'h0123_4567;
        int acc2;
        issue(2'b01, 1'b0, a1, d1, 1'b1);
        cmd_sel = 2'b10; cmd_write = 1'b1; cmd_addr = a2; cmd_wdata = d2;
        rx_frame(NB);
        tests_run++;
        if (!rx_ok) begin
            tests_failed++;
            $display("FAIL b2b_framing1: start/stop bits wrong or line stalled");
        end
        for (int b = 0; b < NB; b++) begin
            tests_run++;
            if (rx_bytes[b] !== exp_byte(2'b01, 1'b0, a1, d1, b)) begin
                tests_failed++;
                $display("FAIL b2b_first_byte%0d: got %h, required %h", b, rx_bytes[b],
                         exp_byte(2'b01, 1'b0, a1, d1, b));
            end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || cyc - acc_cyc != DONE_LAT + 1) begin
            tests_failed++;
            $display("FAIL b2b_ready_return: ready=%b at %0d cycles, required 1 at %0d",
                     cmd_ready, cyc - acc_cyc, DONE_LAT + 1);
        end
        acc2 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if ({cmd_ready, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_second_accept: {ready,busy}=%b, required 01", {cmd_ready, busy});
        end
        rx_frame(NB);
        tests_run++;
        if (!rx_ok || start_cyc !== acc2 + 2) begin
            tests_failed++;
            $display("FAIL b2b_framing2: ok=%0d start=%0d cycles, required ok=1 start=2",
                     rx_ok, start_cyc - acc2);
        end
        for (int b = 0; b < NB; b++) begin
            tests_run++;
            if (rx_bytes[b] !== exp_byte(2'b10, 1'b1, a2, d2, b)) begin
                tests_failed++;
                $display("FAIL b2b_second_byte%0d: got %h, required %h", b, rx_bytes[b],
                         exp_byte(2'b10, 1'b1, a2, d2, b));
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int done_n, tx_low;
        issue(2'b01, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        repeat (129) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_busy_in_byte3: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({tx_out, busy, cmd_ready, done} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rst_abort: {tx,busy,ready,done}=%b, required 1000",
                     {tx_out, busy, cmd_ready, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_n = 0; tx_low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_n++;
            if (tx_out !== 1'b1) tx_low++;
        end
        tests_run++;
        if (done_n != 0 || tx_low != 0) begin
            tests_failed++;
            $display("FAIL rst_no_done: done pulses=%0d tx low=%0d, required 0/0", done_n, tx_low);
        end
        issue(2'b10, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0);
        rx_frame(NB);
        tests_run++;
        if (!rx_ok) begin
            tests_failed++;
            $display("FAIL rst_refr_framing: start/stop bits wrong or line stalled");
        end
        for (int b = 0; b < NB; b++) begin
            tests_run++;
            if (rx_bytes[b] !== exp_byte(2'b10, 1'b0, 32'h1234_5678, 32'h0, b)) begin
                tests_failed++;
                $display("FAIL rst_refr_byte%0d: got %h, required %h", b, rx_bytes[b],
                         exp_byte(2'b10, 1'b0, 32'h1234_5678, 32'h0, b));
            end
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_refr_done: done=%b, required 1", done);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_s1();
        test_read_s2();
        test_illegal_sel();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
